// File: rtl/top_level.sv
// Message-encryption engine: pads a stored message with a space preamble, XORs it with a
// 7-bit LFSR keystream, tags each byte with even parity and writes it back to memory.

module data_mem (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] raddr,
   output logic [7:0] rdata,
   output logic [7:0] sel_data,
   output logic [6:0] seed_data
);
   logic [7:0] core [0:255];

   assign rdata     = core[raddr];
   assign sel_data  = core[62];
   assign seed_data = core[63][6:0];

   always_ff @(posedge clk) begin
      if (we) core[waddr] <= wdata;
   end
endmodule

// state | meaning
// IDLE  | waiting for req low, ack low
// SETUP | latch clamped preamble length, taps and seed
// RUN   | encrypt and write one byte per cycle, 64 bytes
// DONE  | ack high until req returns high
module top_level (
   input  logic clk,
   input  logic init,
   input  logic req,
   output logic ack
);
   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

   state_t     state;
   logic [6:0] lfsr;
   logic [6:0] taps;
   logic [5:0] idx;
   logic [4:0] plen;

   logic [7:0] raddr;
   logic [7:0] rdata;
   logic [7:0] sel_data;
   logic [6:0] seed_data;
   logic [5:0] src;
   logic [7:0] pad;
   logic [7:0] c_raw;
   logic [7:0] cipher;
   logic       we;

   data_mem DM (
      .clk       (clk),
      .we        (we),
      .waddr     ({2'b01, idx}),
      .wdata     (cipher),
      .raddr     (raddr),
      .rdata     (rdata),
      .sel_data  (sel_data),
      .seed_data (seed_data)
   );

   function automatic logic [4:0] clamp_len(input logic [7:0] raw);
      if (raw < 8'd10)      clamp_len = 5'd10;
      else if (raw > 8'd26) clamp_len = 5'd26;
      else                  clamp_len = raw[4:0];
   endfunction

   function automatic logic [6:0] tap_sel(input logic [7:0] s);
      if (s == 8'd8) tap_sel = 7'h7B;
      else begin
         case (s[2:0])
            3'd0:    tap_sel = 7'h60;
            3'd1:    tap_sel = 7'h48;
            3'd2:    tap_sel = 7'h78;
            3'd3:    tap_sel = 7'h72;
            3'd4:    tap_sel = 7'h6A;
            3'd5:    tap_sel = 7'h69;
            3'd6:    tap_sel = 7'h5C;
            default: tap_sel = 7'h7E;
         endcase
      end
   endfunction

   // Source index is only meaningful once idx has passed the preamble.
   assign src    = idx - {1'b0, plen};
   assign raddr  = (state == SETUP) ? 8'd61 : {2'b00, src};
   assign pad    = (idx < {1'b0, plen}) ? 8'h20 : rdata;
   assign c_raw  = pad ^ {1'b0, lfsr};
   assign cipher = {^c_raw[6:0], c_raw[6:0]};
   assign we     = (state == RUN);

   always_ff @(posedge clk or negedge init) begin
      if (!init) begin
         state <= IDLE;
         ack   <= 1'b0;
         lfsr  <= 7'd0;
         taps  <= 7'd0;
         idx   <= 6'd0;
         plen  <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               ack <= 1'b0;
               if (!req) state <= SETUP;
            end
            SETUP: begin
               plen  <= clamp_len(rdata);
               taps  <= tap_sel(sel_data);
               lfsr  <= (seed_data == 7'd0) ? 7'd1 : seed_data;
               idx   <= 6'd0;
               state <= RUN;
            end
            RUN: begin
               lfsr <= {lfsr[5:0], ^(lfsr & taps)};
               idx  <= idx + 6'd1;
               if (idx == 6'd63) state <= DONE;
            end
            DONE: begin
               if (req) begin
                  ack   <= 1'b0;
                  state <= IDLE;
               end else begin
                  ack <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_top_level.sv
// Directed and randomized runs of the encryption engine checked against a byte-level model.

module tb_top_level;
   logic clk;
   logic init;
   logic req;
   logic ack;

   int checks = 0;
   int errors = 0;

   logic [7:0] msg [0:60];
   logic [7:0] praw, sel, seed;
   logic [7:0] exp_out [0:63];
   logic [7:0] saved [0:63];
   logic [7:0] snap [0:255];
   int         tap_tab [0:8] = '{'h60, 'h48, 'h78, 'h72, 'h6A, 'h69, 'h5C, 'h7E, 'h7B};

   top_level dut (
      .clk  (clk),
      .init (init),
      .req  (req),
      .ack  (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: spec-level arithmetic over the whole 64-byte frame.
   task automatic compute_model();
      int p, ti, l, pad, c, fb;
      p  = (praw < 10) ? 10 : (praw > 26) ? 26 : int'(praw);
      ti = (sel == 8) ? 8 : int'(sel) % 8;
      l  = int'(seed) % 128;
      if (l == 0) l = 1;
      for (int i = 0; i < 64; i++) begin
         pad = (i < p) ? 32 : int'(msg[i - p]);
         c   = (pad ^ l) % 128;
         c   = c + 128 * ($countones(c) % 2);
         exp_out[i] = c[7:0];
         fb  = $countones(l & tap_tab[ti]) % 2;
         l   = (l * 2) % 128 + fb;
      end
   endtask

   task automatic load_mem();
      for (int i = 0; i < 61; i++) dut.DM.core[i] = msg[i];
      dut.DM.core[61] = praw;
      dut.DM.core[62] = sel;
      dut.DM.core[63] = seed;
      for (int i = 64; i < 256; i++) dut.DM.core[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) snap[i] = dut.DM.core[i];
      compute_model();
   endtask

   task automatic rand_msg();
      for (int i = 0; i < 61; i++) msg[i] = 8'($urandom);
   endtask

   // Next rising edge must be the one that samples req low.
   task automatic run_check(input string tag, input bit toggle);
      int bad;
      @(posedge clk);
      for (int k = 1; k <= 66; k++) begin
         @(posedge clk);
         #1;
         if (toggle && k < 60) req = 1'($urandom);
         if (k == 60) req = 1'b0;
         if (k == 65) chk($sformatf("%s ack_edge65", tag), {31'd0, ack}, 32'd0);
      end
      chk($sformatf("%s ack_edge66", tag), {31'd0, ack}, 32'd1);
      for (int i = 0; i < 64; i++)
         chk($sformatf("%s byte%0d", tag, i), {24'd0, dut.DM.core[64 + i]}, {24'd0, exp_out[i]});
      bad = 0;
      for (int i = 0; i < 64; i++)  if (dut.DM.core[i] !== snap[i]) bad++;
      for (int i = 128; i < 256; i++) if (dut.DM.core[i] !== snap[i]) bad++;
      chk($sformatf("%s untouched", tag), bad, 0);
   endtask

   task automatic release_req(input string tag);
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("%s ack_drop", tag), {31'd0, ack}, 32'd0);
      @(posedge clk);
   endtask

   task automatic full_run(input string tag, input bit toggle);
      load_mem();
      @(negedge clk);
      req = 1'b0;
      run_check(tag, toggle);
      release_req(tag);
   endtask

   initial begin
      string   text;
      logic [7:0] clamp_list [0:5];
      logic [7:0] sel_list [0:2];

      init = 1'b0;
      req  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ack", {31'd0, ack}, 32'd0);
      @(negedge clk);
      init = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_ack", {31'd0, ack}, 32'd0);

      text = "Mr. Watson, come here. I want to see you.";
      for (int i = 0; i < 61; i++) msg[i] = (i < text.len()) ? text[i] : 8'h20;
      praw = 8'd10; sel = 8'h00; seed = 8'h01;
      full_run("watson", 1'b0);
      chk("watson_c64", {24'd0, dut.DM.core[64]}, 32'h21);
      chk("watson_c65", {24'd0, dut.DM.core[65]}, 32'h22);
      chk("watson_c70", {24'd0, dut.DM.core[70]}, 32'hE1);
      chk("watson_c74", {24'd0, dut.DM.core[74]}, 32'h55);
      for (int i = 0; i < 64; i++) saved[i] = dut.DM.core[64 + i];

      seed = 8'h00;
      full_run("seed0", 1'b0);
      for (int i = 0; i < 64; i++)
         chk($sformatf("seed0_vs_seed1 byte%0d", i), {24'd0, dut.DM.core[64 + i]}, {24'd0, saved[i]});

      clamp_list = '{8'd3, 8'd200, 8'd9, 8'd10, 8'd26, 8'd27};
      for (int j = 0; j < 6; j++) begin
         rand_msg();
         praw = clamp_list[j]; sel = 8'($urandom); seed = 8'($urandom);
         full_run($sformatf("clamp%0d", praw), 1'b0);
      end
      chk("clamp200_first", {24'd0, dut.DM.core[64 + 26] ^ {1'b0, 7'h00}} & 32'h7F,
          {24'd0, dut.DM.core[64 + 26]} & 32'h7F);

      sel_list = '{8'h08, 8'h0B, 8'h18};
      for (int j = 0; j < 3; j++) begin
         rand_msg();
         praw = 8'($urandom_range(10, 26)); sel = sel_list[j]; seed = 8'($urandom);
         full_run($sformatf("sel%0h", sel), 1'b0);
      end

      for (int i = 0; i < 61; i++) msg[i] = (i % 2 == 0) ? 8'h9F : 8'($urandom);
      praw = 8'd12; sel = 8'd5; seed = 8'h80;
      full_run("msb9f", 1'b0);

      for (int j = 0; j < 4; j++) begin
         rand_msg();
         praw = 8'($urandom); sel = 8'($urandom); seed = 8'($urandom);
         full_run($sformatf("rand%0d", j), 1'b1);
      end

      rand_msg();
      praw = 8'd15; sel = 8'd2; seed = 8'h33;
      load_mem();
      @(negedge clk);
      req = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      init = 1'b0;
      #1;
      chk("midrun_reset_ack", {31'd0, ack}, 32'd0);
      rand_msg();
      praw = 8'd20; sel = 8'd7; seed = 8'h5A;
      load_mem();
      @(negedge clk);
      init = 1'b1;
      run_check("after_reset", 1'b0);
      @(negedge clk);
      #1;
      init = 1'b0;
      #1;
      chk("done_async_reset_ack", {31'd0, ack}, 32'd0);
      @(negedge clk);
      req  = 1'b1;
      init = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_after_reset", {31'd0, ack}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/top_level.md
# top_level

Hard-wired message-encryption engine with an embedded 256-byte data memory, used as the top of the Program 1 (message encrypt) build. On launch it reads:
- a plaintext message from the low memory bytes;
- a preamble length, an LFSR tap-pattern selector and an LFSR seed from fixed parameter bytes.

It then writes a 64-byte encrypted, parity-tagged message to bytes 64–127 and raises a done flag. All operand and result transfer happens through the memory, which the testbench accesses hierarchically.

## Interface
- Parameters: none.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `init`  in  1  asynchronous, active-low reset.
- `req`  in  1  start request. High holds the engine idle; the engine launches when `req` is sampled low.
- `ack`  out  1  program-complete flag.
- Internal memory: instance `DM`, array `core[0:255]`, 8 bits wide.
  - Read is combinational; write is synchronous.
  - Reachable hierarchically as `DM.core`.
  - Reset never clears it.

## Operation
- Memory map (inputs):
  - `core[0..60]` = message, space-padded (0x20).
  - `core[61]` = preamble length, raw.
  - `core[62]` = pattern selector, raw.
  - `core[63]` = LFSR seed.
- Memory map (output): `core[64..127]` = ciphertext bytes 0..63.
- Preamble length P is clamped from `core[61]`: P = 10 if raw < 10; P = 26 if raw > 26; otherwise P = raw.
- Tap pattern is selected from the 8-bit selector S: index = 8 if S == 8 exactly, else index = S[2:0].
- Tap table, index 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- Seed: L0 = `core[63][6:0]`. If L0 is zero, the engine uses 0x01.
- LFSR (7 bits): L(i+1) = {L(i)[5:0], ^(L(i) & taps)}.
- Padded byte for i = 0..63:
  - PAD(i) = 0x20 when i < P;
  - otherwise PAD(i) = `core[i−P]`. Source index never exceeds 53.
- Ciphertext: C = PAD(i) ^ {1'b0, L(i)}, then C[7] is replaced by ^C[6:0] (even parity over the low 7 bits).
- Write C to `core[64+i]`.
- Bytes 0..127 other than the output region are never written. Bytes 128–255 are left untouched (scratch).

## Timing
- Reset (`init` = 0, async): state = IDLE, `ack` = 0, LFSR / index / parameter registers cleared. Memory is retained.
- FSM states:
  - IDLE: `ack` = 0. Goes to SETUP on the first rising edge with `req` = 0.
  - SETUP: one cycle. Latches clamped P, taps and seed (zero-fix applied). Sets i = 0.
  - RUN: one byte per cycle. Computes C from combinational reads, writes `core[64+i]`, advances LFSR and i. After i = 63 it goes to DONE.
  - DONE: `ack` = 1, held. Goes back to IDLE when `req` = 1.
- Latency: `ack` rises on the 66th rising edge after the edge that samples `req` low (1 SETUP + 64 RUN + 1 DONE entry).
- `ack` is registered and glitch-free.
- `req` toggling during SETUP/RUN is ignored. The run always completes.
- Reset mid-run aborts immediately. Output bytes already written stay in memory; the next launch rewrites all 64.
- If `req` is already low when reset releases, the engine launches on the first edge.

## Test plan
- Taps index 0 (selector 0x00), seed 0x01, `core[61]` = 10, message "Mr. Watson, come here. I want to see you.":
  - `core[64]` = 0x21, `core[65]` = 0x22, `core[70]` = 0xE1, `core[74]` = 0x55 ('M' ^ 0x18).
  - All 64 bytes match the reference model.
  - `ack` = 1 exactly 66 edges after launch.
- Preamble clamp:
  - `core[61]` = 3 → bytes 64..73 encrypt spaces and `core[74]` encrypts `core[0]`.
  - `core[61]` = 200 → first message byte lands at `core[90]`.
- Pattern select:
  - selector 0x08 → taps 0x7B;
  - selector 0x0B → taps 0x72;
  - selector 0x18 → taps 0x60;
  - all outputs match the model.
- Seed `core[63]` = 0x00 → output identical to the run with seed 0x01.
- Message containing 0x9F: C[7] equals parity of the XOR result, not the input MSB.
- Control behaviour:
  - Assert `init` low mid-RUN → `ack` drops to 0 asynchronously.
  - After release with `req` low, a complete correct run and `ack` follow.
  - In DONE, `req` high → `ack` = 0 next edge.
